// File: rtl/rd_ptr_empty_ctrl.sv
// Read-domain pointer and flag controller for an async FIFO: synchronises the
// write Gray pointer into r_clk and keeps the read pointer, empty, almost-empty, level and underflow.
module rd_ptr_empty_ctrl #(
  parameter int unsigned ADDR_SIZE   = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 2
) (
  input  logic                 r_clk,
  input  logic                 r_rst,
  input  logic [ADDR_SIZE:0]   w_ptr_gray,
  input  logic                 r_en,
  input  logic                 r_underflow_clr,
  output logic [ADDR_SIZE-1:0] r_addr,
  output logic [ADDR_SIZE:0]   r_ptr_gray,
  output logic                 r_empty,
  output logic                 r_almost_empty,
  output logic [ADDR_SIZE:0]   r_level,
  output logic                 r_underflow
);

  localparam int unsigned PW = ADDR_SIZE + 1;

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wq;
  logic [PW-1:0] wq_bin;
  logic [PW-1:0] r_ptr_bin;
  logic [PW-1:0] ptr_bin_next;
  logic [PW-1:0] ptr_gray_next;
  logic [PW-1:0] level_next;
  logic          rd_ok;

  // Plain flop chain for the clock-domain crossing; nothing between stages.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= w_ptr_gray;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wq = sync_q[SYNC_STAGES-1];

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wq_bin = '0;
    for (int i = 0; i < int'(PW); i++) wq_bin[i] = ^(wq >> i);
  end

  assign rd_ok         = r_en & ~r_empty;
  assign ptr_bin_next  = r_ptr_bin + PW'(rd_ok);
  assign ptr_gray_next = ptr_bin_next ^ (ptr_bin_next >> 1);
  assign level_next    = wq_bin - ptr_bin_next;
  assign r_addr        = r_ptr_bin[ADDR_SIZE-1:0];

  // Flags come from the next-state pointer so they are exact after the edge.
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      r_ptr_bin      <= '0;
      r_ptr_gray     <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_level        <= '0;
      r_underflow    <= 1'b0;
    end else begin
      r_ptr_bin      <= ptr_bin_next;
      r_ptr_gray     <= ptr_gray_next;
      r_empty        <= (ptr_gray_next == wq);
      r_almost_empty <= (level_next <= PW'(AE_THRESH));
      r_level        <= level_next;
      r_underflow    <= (r_en & r_empty) | (r_underflow & ~r_underflow_clr);
    end
  end

endmodule

// File: tb/tb_rd_ptr_empty_ctrl.sv
// Bench for rd_ptr_empty_ctrl: directed vector table, level/wrap/reset sequences and
// random traffic, all compared against an occupancy-counting reference model.
module tb_rd_ptr_empty_ctrl;

  localparam int AS = 4;
  localparam int SS = 2;
  localparam int AE = 2;
  localparam int PM = 32;

  logic          r_clk = 1'b0;
  logic          r_rst = 1'b0;
  logic [AS:0]   w_ptr_gray = '0;
  logic          r_en = 1'b0;
  logic          r_underflow_clr = 1'b0;
  logic [AS-1:0] r_addr;
  logic [AS:0]   r_ptr_gray;
  logic          r_empty;
  logic          r_almost_empty;
  logic [AS:0]   r_level;
  logic          r_underflow;

  rd_ptr_empty_ctrl #(.ADDR_SIZE(AS), .SYNC_STAGES(SS), .AE_THRESH(AE)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .w_ptr_gray(w_ptr_gray), .r_en(r_en),
    .r_underflow_clr(r_underflow_clr), .r_addr(r_addr), .r_ptr_gray(r_ptr_gray),
    .r_empty(r_empty), .r_almost_empty(r_almost_empty), .r_level(r_level),
    .r_underflow(r_underflow)
  );

  always #5 r_clk = ~r_clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: counts of items written and read, with the writer's count
  // seen SS edges late.
  int m_rd;
  int m_hist [SS];
  int m_level;
  bit m_empty, m_ae, m_uf;
  int wbin;

  function automatic int bin2gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rd = 0; m_level = 0; m_empty = 1; m_ae = 1; m_uf = 0;
    for (int i = 0; i < SS; i++) m_hist[i] = 0;
  endtask

  task automatic model_edge(input int wb, input bit en, input bit clr);
    int seen;
    bit ok;
    seen = m_hist[SS-1];
    for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = wb;
    ok    = en && !m_empty;
    m_uf  = (en && m_empty) || (m_uf && !clr);
    m_rd  = (m_rd + (ok ? 1 : 0)) % PM;
    m_level = (seen - m_rd + PM) % PM;
    m_empty = (m_level == 0);
    m_ae    = (m_level <= AE);
  endtask

  task automatic check_model();
    check("empty", int'(r_empty), int'(m_empty));
    check("almost_empty", int'(r_almost_empty), int'(m_ae));
    check("level", int'(r_level), m_level);
    check("underflow", int'(r_underflow), int'(m_uf));
    check("addr", int'(r_addr), m_rd % 16);
    check("ptr_gray", int'(r_ptr_gray), bin2gray(m_rd));
  endtask

  // Apply inputs just after an edge, advance one edge, compare 1ns later.
  task automatic step(input int wb, input bit en, input bit clr);
    wbin = wb % PM;
    w_ptr_gray = (AS+1)'(bin2gray(wbin));
    r_en = en;
    r_underflow_clr = clr;
    model_edge(wbin, en, clr);
    @(posedge r_clk);
    #1;
    check_model();
  endtask

  typedef struct {
    int w; bit en; bit clr;
    bit empty; int level; bit ae; bit uf; int addr;
  } vec_t;

  vec_t vecs [14];

  initial begin
    // w en clr | empty level ae uf addr
    vecs[0]  = '{1, 0, 0, 1, 0, 1, 0, 0};
    vecs[1]  = '{1, 0, 0, 1, 0, 1, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 1, 1, 0, 0};
    vecs[3]  = '{1, 1, 0, 1, 0, 1, 0, 1};
    vecs[4]  = '{1, 1, 0, 1, 0, 1, 1, 1};
    vecs[5]  = '{1, 1, 0, 1, 0, 1, 1, 1};
    vecs[6]  = '{1, 1, 0, 1, 0, 1, 1, 1};
    vecs[7]  = '{1, 0, 1, 1, 0, 1, 0, 1};
    vecs[8]  = '{1, 1, 1, 1, 0, 1, 1, 1};
    vecs[9]  = '{1, 0, 0, 1, 0, 1, 1, 1};
    vecs[10] = '{1, 0, 1, 1, 0, 1, 0, 1};
    vecs[11] = '{17, 0, 0, 1, 0, 1, 0, 1};
    vecs[12] = '{17, 0, 0, 1, 0, 1, 0, 1};
    vecs[13] = '{17, 0, 0, 0, 16, 0, 0, 1};

    // Reset held with a pending read and random write pointer.
    model_reset();
    r_en = 1'b1;
    w_ptr_gray = (AS+1)'($urandom_range(0, 31));
    repeat (3) @(posedge r_clk);
    #1;
    check("rst_empty", int'(r_empty), 1);
    check("rst_ae", int'(r_almost_empty), 1);
    check("rst_gray", int'(r_ptr_gray), 0);
    check("rst_addr", int'(r_addr), 0);
    check("rst_level", int'(r_level), 0);
    check("rst_uf", int'(r_underflow), 0);
    r_en = 1'b0;
    w_ptr_gray = '0;
    wbin = 0;
    r_rst = 1'b1;

    // Single write, read, underflow set/clear, level 16.
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].w, vecs[i].en, vecs[i].clr);
      check($sformatf("vec%0d_empty", i), int'(r_empty), int'(vecs[i].empty));
      check($sformatf("vec%0d_level", i), int'(r_level), vecs[i].level);
      check($sformatf("vec%0d_ae", i), int'(r_almost_empty), int'(vecs[i].ae));
      check($sformatf("vec%0d_uf", i), int'(r_underflow), int'(vecs[i].uf));
      check($sformatf("vec%0d_addr", i), int'(r_addr), vecs[i].addr);
    end

    // Drain 14 to the almost-empty threshold, then 2 more to empty.
    for (int i = 0; i < 14; i++) step(17, 1, 0);
    check("lvl_after14", int'(r_level), 2);
    check("ae_after14", int'(r_almost_empty), 1);
    check("empty_after14", int'(r_empty), 0);
    step(17, 1, 0);
    step(17, 1, 0);
    check("empty_after16", int'(r_empty), 1);
    check("addr_after16", int'(r_addr), 1);

    // Mid-operation reset at level 5.
    step(22, 0, 0);
    repeat (3) step(22, 0, 0);
    check("midop_level", int'(r_level), 5);
    #2;
    r_rst = 1'b0;
    #1;
    model_reset();
    check("midop_rst_empty", int'(r_empty), 1);
    check("midop_rst_level", int'(r_level), 0);
    check("midop_rst_gray", int'(r_ptr_gray), 0);
    check("midop_rst_addr", int'(r_addr), 0);
    check("midop_rst_ae", int'(r_almost_empty), 1);
    @(posedge r_clk);
    #1;
    w_ptr_gray = '0;
    wbin = 0;
    r_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1);
      check("post_rst_empty", int'(r_empty), 1);
    end
    step(0, 0, 1);

    // Wrap: 40 single write/read pairs.
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 3; k++) step(i + 1, 0, 0);
      check("wrap_not_empty", int'(r_empty), 0);
      step(i + 1, 1, 0);
      check("wrap_addr", int'(r_addr), (i + 1) % 16);
      check("wrap_gray", int'(r_ptr_gray), bin2gray((i + 1) % 32));
    end

    // Random traffic; writer never exceeds 16 outstanding items.
    for (int i = 0; i < 600; i++) begin
      int nw;
      nw = wbin;
      if ((wbin - m_rd + PM) % PM < 16 && ($urandom % 2) == 1)
        nw = (wbin + 1) % PM;
      step(nw, ($urandom % 3) != 0, ($urandom % 8) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
